timer_sched: RTL and testbench
==============================

// Module: timer_sched
// PURPOSE
//  Shares one 16-bit countdown timer between NREQ requesters.
//  - Round-robin arbitration between requesters.
//  - Loads the granted delay into the timer through its load/cycles/busy interface.
//  - Waits for busy to fall, then returns a one-cycle done pulse to the granted requester.
//  - Sits between the request-side logic and a single timer instance.
// PARAMETERS
//  NREQ   4   number of requesters, 2..8
//  WIDTH  16  delay width; matches the timer cycles port
// PORTS
//  clk           in   1           rising-edge clock
//  reset_n       in   1           asynchronous, active-low reset
//  req           in   NREQ        per-requester level request; hold until done
//  req_cycles    in   NREQ*WIDTH  delay for requester i in bits [i*WIDTH +: WIDTH]
//  gnt           out  NREQ        one-hot owner of the timer; 0 when idle
//  done          out  NREQ        one-cycle pulse to the owner when its delay expires
//  timer_load    out  1           to timer load
//  timer_cycles  out  WIDTH       to timer cycles; valid while timer_load=1
//  timer_busy    in   1           from timer busy
//  timer_clear   out  1           to timer reset (active-high, synchronous); see CONFIGURATION
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - State IDLE, RR pointer 0.
//   - gnt, done, timer_load, timer_clear, timer_cycles all 0.
//  FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
//  IDLE:
//   - Arbitrates only when |req && !timer_busy.
//   - Timer may still be running after a controller-only reset; IDLE waits it out.
//   - Winner: first set req bit at or after the pointer, wrapping modulo NREQ.
//   - Latches winner index and req_cycles; sets gnt.
//   - Latched cycles != 0 -> LOAD. Latched cycles == 0 -> DONE; the timer is never loaded with 0.
//  LOAD: timer_load=1 for exactly one cycle, timer_cycles = latched value -> RUN.
//  RUN: stays while timer_busy=1; timer_busy=0 -> DONE.
//  DONE:
//   - done[idx]=1 for one cycle, gnt held this cycle.
//   - Pointer <= idx+1 mod NREQ -> IDLE with gnt=0.
//  Latency: req sampled in IDLE at cycle 0, C cycles:
//   - C>0: load at cycle 1, busy cycles 2..C+1, done at cycle C+3.
//   - C=0: done at cycle 1.
//  Back-to-back: the next grant is issued in the cycle after DONE at the earliest. Timer idle gap >= 2 cycles.
//  req_cycles is sampled only at grant; later changes are ignored.
//  Owner drops req mid-delay: ignored; the delay completes and done still pulses.
//  Requester holding req after its done: re-arbitrated, but behind the others (fairness).
//  Simultaneous requests: pointer order decides; other reqs wait, none is lost.
//  Unexpected timer_busy=0 in the first RUN cycle: treated as expiry -> DONE.
// CONFIGURATION
//  TIMER_SCHED_ABORT_EN defined:
//   - Adds input abort (1) and output done_aborted (1).
//   - abort=1 in LOAD or RUN: timer_clear=1 for one cycle, then DONE.
//   - In that DONE: done[idx]=1 and done_aborted=1.
//   - abort in IDLE or DONE is ignored.
//  TIMER_SCHED_ABORT_EN undefined: abort and done_aborted ports absent; timer_clear tied 0.
// STRUCTURE
//  Package timer_sched_pkg:
//   - state_t enum {IDLE, LOAD, RUN, DONE}.
//   - Parameter defaults NREQ_DEF=4, WIDTH_DEF=16.
//   - Function idx_w(NREQ) giving the index width.
//  Sub-module rr_pick (combinational): inputs req and pointer; outputs one-hot winner and its index.
//  Top holds the FSM, pointer, latched index and latched cycles. The timer itself is instantiated by the parent.
// TESTING (bench instantiates timer_sched plus one timer)
//  1 req=0001, cycles0=3 at cycle 0 -> timer_load at 1, gnt=0001 cycles 1..6, done=0001 at cycle 6 only.
//  2 req=1111 held continuously, all cycles=2 -> grants in order 0,1,2,3,0; never two gnt bits set.
//  3 req=0100, cycles2=0 -> done=0100 one cycle after sampling; timer_load never asserted.
//  4 reset_n=0 in RUN with cycles=10 -> gnt/done 0 immediately; after release, new req waits until timer_busy=0.
//  5 req0 dropped mid-RUN and req_cycles0 changed -> original delay completes; done=0001 still pulses.
//  6 (ABORT_EN) abort in RUN of cycles=50 -> timer_clear 1 cycle, next cycle done=0001 and done_aborted=1.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg
// Shared types and helpers for the timer_sched controller.
//   state_t    controller FSM states
//   NREQ_DEF   default number of requesters
//   WIDTH_DEF  default delay width (matches the timer cycles port)
//   idx_w()    width of a requester index for a given requester count
package timer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 16;

  // A single requester still needs one index bit so vectors stay legal.
  function automatic int idx_w(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/timer_sched_rr_pick.sv
// rr_pick
// Combinational round-robin picker: first set request bit at or after the
// pointer, wrapping modulo NREQ.
// Ports:
//   req      in   NREQ  request vector
//   ptr      in   IW    search start index
//   win      out  NREQ  one-hot winner, 0 when no request
//   win_idx  out  IW    index of the winner, 0 when no request
module rr_pick
  import timer_sched_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx
);

  int   j;
  logic found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        win[j]  = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// timer_sched
// Shares one countdown timer between NREQ requesters. Round-robin grant,
// loads the granted delay into the timer, waits for busy to fall and pulses
// done to the owner.
// Optional feature macro: TIMER_SCHED_ABORT_EN (adds abort / done_aborted and
// drives timer_clear; without it timer_clear is constant 0).
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   req            in   per-requester level request, held until done
//   req_cycles     in   delay for requester i in [i*WIDTH +: WIDTH]
//   gnt            out  one-hot owner, 0 when idle
//   done           out  one-cycle pulse to the owner at expiry
//   timer_load     out  timer load strobe
//   timer_cycles   out  timer load value, valid with timer_load
//   timer_busy     in   timer busy
//   timer_clear    out  timer synchronous clear
//   abort          in   (ABORT_EN) cancel the running delay
//   done_aborted   out  (ABORT_EN) qualifies done as an aborted delay
//
// state | meaning
// IDLE  | no owner; arbitrate when a request is pending and the timer is idle
// LOAD  | owner latched; one-cycle load of the latched delay into the timer
// RUN   | timer counting; leave when busy falls
// DONE  | done pulse to owner; pointer moves past owner
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_cycles,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  timer_load,
  output logic [WIDTH-1:0]      timer_cycles,
  input  logic                  timer_busy,
  output logic                  timer_clear
`ifdef TIMER_SCHED_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  done_aborted
`endif
);

  localparam int IW = idx_w(NREQ);

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] cyc;
  logic [NREQ-1:0]  win;
  logic [IW-1:0]    win_idx;
  logic [WIDTH-1:0] win_cycles;
  logic [NREQ-1:0]  owner;
  logic             arb;
  logic             abort_hit;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  // A timer left running by a controller-only reset must expire before
  // anyone is granted.
  assign arb        = (|req) && !timer_busy;
  assign win_cycles = req_cycles[int'(win_idx)*WIDTH +: WIDTH];

`ifdef TIMER_SCHED_ABORT_EN
  logic aborted;

  assign abort_hit    = abort && ((state == LOAD) || (state == RUN));
  assign done_aborted = (state == DONE) && aborted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            aborted <= 1'b0;
    else if (abort_hit)      aborted <= 1'b1;
    else if (state == DONE)  aborted <= 1'b0;
  end
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    owner      = '0;
    owner[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      cyc   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && arb) begin
        idx <= win_idx;
        cyc <= win_cycles;
      end
      if (state == DONE)
        ptr <= (idx == IW'(NREQ-1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt          = '0;
    done         = '0;
    timer_load   = 1'b0;
    timer_cycles = '0;
    timer_clear  = 1'b0;
    case (state)
      IDLE: begin
        // A zero delay never reaches the timer; it completes straight away.
        if (arb) state_nxt = (win_cycles != '0) ? LOAD : DONE;
      end
      LOAD: begin
        gnt = owner;
        if (abort_hit) begin
          timer_clear = 1'b1;
          state_nxt   = DONE;
        end else begin
          timer_load   = 1'b1;
          timer_cycles = cyc;
          state_nxt    = RUN;
        end
      end
      RUN: begin
        gnt = owner;
        if (abort_hit) begin
          timer_clear = 1'b1;
          state_nxt   = DONE;
        end else if (!timer_busy) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        gnt       = owner;
        done      = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_sched.sv
module tb_timer_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic                  clk;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_cycles;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  timer_load;
  logic [WIDTH-1:0]      timer_cycles;
  logic                  timer_busy;
  logic                  timer_clear;
`ifdef TIMER_SCHED_ABORT_EN
  logic                  abort;
  logic                  done_aborted;
`endif

  logic                  timer_por;
  logic [WIDTH-1:0]      tcnt;

  int errors;
  int checks;

  timer_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_cycles   (req_cycles),
    .gnt          (gnt),
    .done         (done),
    .timer_load   (timer_load),
    .timer_cycles (timer_cycles),
    .timer_busy   (timer_busy),
    .timer_clear  (timer_clear)
`ifdef TIMER_SCHED_ABORT_EN
    ,
    .abort        (abort),
    .done_aborted (done_aborted)
`endif
  );

  always #5 clk = ~clk;

  // Countdown timer: busy for exactly N cycles after a load of N.
  always @(posedge clk) begin
    if (timer_por || timer_clear) tcnt <= '0;
    else if (timer_load)          tcnt <= timer_cycles;
    else if (tcnt != '0)          tcnt <= tcnt - 16'd1;
  end
  assign timer_busy = (tcnt != '0);

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbitration: first requester at or after ptr, wrapping.
  function automatic int rr_ref(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (p + i) % NREQ;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_cyc(input int lane, input logic [WIDTH-1:0] v);
    req_cycles[lane*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    timer_por  = 1'b1;
    req        = '0;
    req_cycles = '0;
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    timer_por = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (gnt == '0 && !timer_busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle_timeout gnt=%b busy=%b want gnt=0 busy=0", name, gnt, timer_busy);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({gnt, done, timer_load, timer_clear} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl gnt=%b done=%b load=%b clear=%b want all 0",
               gnt, done, timer_load, timer_clear);
    end
    checks++;
    if (timer_cycles !== '0) begin
      errors++;
      $display("FAIL reset_cycles got=%0d want=0", timer_cycles);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [NREQ-1:0] eg, ed;
    do_reset();
    req = 4'b0001;
    set_cyc(0, 16'd3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      eg = (k <= 6) ? 4'b0001 : 4'b0000;
      ed = (k == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (gnt !== eg) begin
        errors++; $display("FAIL single_gnt k=%0d got=%b want=%b", k, gnt, eg);
      end
      checks++;
      if (done !== ed) begin
        errors++; $display("FAIL single_done k=%0d got=%b want=%b", k, done, ed);
      end
      checks++;
      if (timer_load !== (k == 1)) begin
        errors++; $display("FAIL single_load k=%0d got=%b want=%b", k, timer_load, (k == 1));
      end
      checks++;
      if (timer_clear !== 1'b0) begin
        errors++; $display("FAIL single_clear k=%0d got=%b want=0", k, timer_clear);
      end
      if (k == 1) begin
        checks++;
        if (timer_cycles !== 16'd3) begin
          errors++; $display("FAIL single_cycles got=%0d want=3", timer_cycles);
        end
      end
      if (k == 6) req = 4'b0000;
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    logic [NREQ-1:0] prev;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_cyc(i, 16'd2);
    req  = 4'b1111;
    prev = '0;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      @(negedge clk);
      checks++;
      if (!$onehot0(gnt)) begin
        errors++; $display("FAIL rr_onehot got=%b want at most one bit", gnt);
      end
      if (gnt != '0 && prev == '0) order.push_back(idx_of(gnt));
      prev = gnt;
    end
    req = '0;
    wait_idle("rr", 50);
    checks++;
    if (order.size() != 5) begin
      errors++; $display("FAIL rr_count got=%0d want=5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != i % NREQ) begin
          errors++; $display("FAIL rr_order grant=%0d got=%0d want=%0d", i, order[i], i % NREQ);
        end
      end
    end
  endtask

  task automatic test_zero_delay();
    logic [NREQ-1:0] e;
    req = 4'b0100;
    set_cyc(2, 16'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e = (k == 1) ? 4'b0100 : 4'b0000;
      checks++;
      if (gnt !== e || done !== e) begin
        errors++; $display("FAIL zero_gnt_done k=%0d gnt=%b done=%b want=%b", k, gnt, done, e);
      end
      checks++;
      if (timer_load !== 1'b0) begin
        errors++; $display("FAIL zero_load k=%0d got=%b want=0", k, timer_load);
      end
      if (k == 1) req = '0;
    end
  endtask

  task automatic test_drop_mid_run();
    logic [NREQ-1:0] eg, ed;
    req = 4'b0001;
    set_cyc(0, 16'd8);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      eg = (k <= 11) ? 4'b0001 : 4'b0000;
      ed = (k == 11) ? 4'b0001 : 4'b0000;
      checks++;
      if (gnt !== eg) begin
        errors++; $display("FAIL drop_gnt k=%0d got=%b want=%b", k, gnt, eg);
      end
      checks++;
      if (done !== ed) begin
        errors++; $display("FAIL drop_done k=%0d got=%b want=%b", k, done, ed);
      end
      if (k == 1) begin
        checks++;
        if (timer_cycles !== 16'd8) begin
          errors++; $display("FAIL drop_cycles got=%0d want=8", timer_cycles);
        end
      end
      if (k == 3) begin
        req = 4'b0000;
        set_cyc(0, 16'd2);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic pb, granted, seen;
    req = 4'b0001;
    set_cyc(0, 16'd10);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || done !== '0) begin
      errors++; $display("FAIL rst_run_outputs gnt=%b done=%b want 0", gnt, done);
    end
    checks++;
    if (timer_busy !== 1'b1) begin
      errors++; $display("FAIL rst_run_timer busy=%b want=1", timer_busy);
    end
    @(negedge clk);
    pb      = timer_busy;
    reset_n = 1'b1;
    granted = 1'b0;
    for (int c = 0; c < 40 && !granted; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== (pb ? 4'b0000 : 4'b0001)) begin
        errors++;
        $display("FAIL rst_wait_gnt busy_at_edge=%b got=%b want=%b", pb, gnt, (pb ? 4'b0000 : 4'b0001));
      end
      if (gnt == 4'b0001) granted = 1'b1;
      pb = timer_busy;
    end
    checks++;
    if (!granted) begin
      errors++; $display("FAIL rst_regrant_timeout gnt=%b want=0001", gnt);
    end
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (done == 4'b0001) begin
        seen = 1'b1;
        req  = '0;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rst_regrant_done got=%b want=0001", done);
    end
    req = '0;
    wait_idle("rst", 30);
  endtask

  task automatic test_random();
    logic            in_txn, prev_idle, just_done;
    int              owner, done_owner, ptr_m, t, dn_t, e, grants;
    logic [WIDTH-1:0] exp_c;
    logic [NREQ-1:0] eg;
    int              v;
    do_reset();
    in_txn = 1'b0; prev_idle = 1'b1; ptr_m = 0; grants = 0;
    owner = 0; done_owner = 0; t = 0; dn_t = 0; exp_c = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      just_done = 1'b0;
      if (!in_txn) begin
        if (prev_idle) begin
          e  = rr_ref(req, ptr_m);
          eg = (e < 0) ? 4'b0000 : oh(e);
          checks++;
          if (gnt !== eg) begin
            errors++; $display("FAIL rnd_grant cyc=%0d req=%b got=%b want=%b", cyc, req, gnt, eg);
          end
          if (e >= 0) begin
            in_txn = 1'b1;
            owner  = e;
            exp_c  = req_cycles[e*WIDTH +: WIDTH];
            t      = 0;
            grants++;
          end
        end else begin
          checks++;
          if (gnt !== '0) begin
            errors++; $display("FAIL rnd_gap cyc=%0d got=%b want=0000", cyc, gnt);
          end
          prev_idle = 1'b1;
        end
      end
      if (in_txn) begin
        dn_t = (exp_c == '0) ? 0 : int'(exp_c) + 2;
        checks++;
        if (gnt !== oh(owner)) begin
          errors++; $display("FAIL rnd_hold cyc=%0d got=%b want=%b", cyc, gnt, oh(owner));
        end
        checks++;
        if (timer_load !== (t == 0 && exp_c != '0)) begin
          errors++; $display("FAIL rnd_load cyc=%0d t=%0d got=%b want=%b", cyc, t, timer_load, (t == 0 && exp_c != '0));
        end
        eg = (t == dn_t) ? oh(owner) : 4'b0000;
        checks++;
        if (done !== eg) begin
          errors++; $display("FAIL rnd_done cyc=%0d t=%0d c=%0d got=%b want=%b", cyc, t, exp_c, done, eg);
        end
        if (t >= dn_t) begin
          in_txn     = 1'b0;
          prev_idle  = 1'b0;
          just_done  = 1'b1;
          done_owner = owner;
          ptr_m      = (owner + 1) % NREQ;
        end
        t++;
      end else begin
        checks++;
        if (done !== '0) begin
          errors++; $display("FAIL rnd_spurious_done cyc=%0d got=%b want=0000", cyc, done);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (in_txn && i == owner) begin
          if (req[i] && $urandom_range(7) == 0) req[i] = 1'b0;
        end else if (just_done && i == done_owner) begin
          req[i] = 1'($urandom_range(1));
        end else if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
        end
        v = int'($urandom_range(7));
        if (v == 7) v = 0;
        set_cyc(i, 16'(v));
      end
    end
    req = '0;
    wait_idle("rnd", 40);
    checks++;
    if (grants < 50) begin
      errors++; $display("FAIL rnd_grant_count got=%0d want>=50", grants);
    end
  endtask

`ifdef TIMER_SCHED_ABORT_EN
  task automatic test_abort();
    do_reset();
    req = 4'b0001;
    set_cyc(0, 16'd50);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    #1;
    checks++;
    if (timer_clear !== 1'b1) begin
      errors++; $display("FAIL abort_clear got=%b want=1", timer_clear);
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (done !== 4'b0001 || done_aborted !== 1'b1) begin
      errors++; $display("FAIL abort_done done=%b aborted=%b want 0001/1", done, done_aborted);
    end
    checks++;
    if (timer_busy !== 1'b0 || timer_clear !== 1'b0) begin
      errors++; $display("FAIL abort_timer busy=%b clear=%b want 0/0", timer_busy, timer_clear);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || done_aborted !== 1'b0) begin
      errors++; $display("FAIL abort_after gnt=%b aborted=%b want 0/0", gnt, done_aborted);
    end
  endtask
`endif

  initial begin
    errors     = 0;
    checks     = 0;
    clk        = 1'b0;
    reset_n    = 1'b0;
    timer_por  = 1'b1;
    req        = '0;
    req_cycles = '0;
`ifdef TIMER_SCHED_ABORT_EN
    abort      = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_zero_delay();
    test_drop_mid_run();
    test_reset_mid_run();
    test_random();
`ifdef TIMER_SCHED_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
